// File: rtl/lvds_align_ctrl.sv
// Link bring-up sequencer for an LVDS tx/rx pair: trains the lane, bitslips rx until aligned.
// Define LVDS_ALIGN_STAT_EN to build the saturating lock-loss retrain counter on realign_cnt_o.
module lvds_align_ctrl #(
  parameter int unsigned          DATA_W     = 8,
  parameter logic [DATA_W-1:0]    TRAIN_PAT  = 8'hF1,
  parameter int unsigned          MATCH_CNT  = 4,
  parameter int unsigned          SETTLE_CYC = 6,
  parameter int unsigned          ALIGN_HI   = 2,
  parameter int unsigned          MAX_SLIPS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              tx_locked_i,
  input  logic              rx_locked_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic [DATA_W-1:0] user_tx_i,
  output logic [DATA_W-1:0] tx_in_o,
  output logic              rx_data_align_o,
  output logic              aligned_o,
  output logic              align_err_o,
  output logic [3:0]        slip_cnt_o,
  output logic [15:0]       realign_cnt_o
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_LOCK = 3'd1;
  localparam logic [2:0] SETTLE    = 3'd2;
  localparam logic [2:0] CHECK     = 3'd3;
  localparam logic [2:0] SLIP      = 3'd4;
  localparam logic [2:0] ALIGNED   = 3'd5;
  localparam logic [2:0] ERROR     = 3'd6;

  localparam int unsigned HI_W = $clog2(ALIGN_HI + 1);

  logic [2:0]      state_q, state_d;
  logic [3:0]      settle_q, settle_d;
  logic [3:0]      match_q, match_d;
  logic [HI_W-1:0] hi_q, hi_d;
  logic            align_q, align_d;
  logic            aligned_q, aligned_d;
  logic            err_q, err_d;
  logic [3:0]      slip_q, slip_d;
  logic            lock_lost_s;
  logic            train_en_s;

  always_comb begin
    lock_lost_s = 1'b0;
    train_en_s  = 1'b0;
    case (state_q)
      WAIT_LOCK: train_en_s = 1'b1;
      SETTLE, CHECK, SLIP: begin
        train_en_s  = 1'b1;
        lock_lost_s = ~(tx_locked_i & rx_locked_i);
      end
      ALIGNED: lock_lost_s = ~(tx_locked_i & rx_locked_i);
      default: begin
        lock_lost_s = 1'b0;
        train_en_s  = 1'b0;
      end
    endcase
  end

  assign tx_in_o = train_en_s ? TRAIN_PAT : user_tx_i;

  // Restart and lock loss both fall back to WAIT_LOCK and override any compare result.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    match_d   = match_q;
    hi_d      = hi_q;
    align_d   = align_q;
    aligned_d = aligned_q;
    err_d     = err_q;
    slip_d    = slip_q;
    if (start_i || lock_lost_s) begin
      state_d   = WAIT_LOCK;
      settle_d  = 4'd0;
      match_d   = 4'd0;
      hi_d      = '0;
      align_d   = 1'b0;
      aligned_d = 1'b0;
      slip_d    = 4'd0;
      err_d     = start_i ? 1'b0 : err_q;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        WAIT_LOCK: begin
          if (tx_locked_i && rx_locked_i) begin
            state_d  = SETTLE;
            settle_d = 4'd0;
          end else begin
            state_d = WAIT_LOCK;
          end
        end
        SETTLE: begin
          if (settle_q == 4'(SETTLE_CYC - 1)) begin
            state_d = CHECK;
            match_d = 4'd0;
          end else begin
            settle_d = settle_q + 4'd1;
          end
        end
        CHECK: begin
          if (rx_data_i == TRAIN_PAT) begin
            if (match_q + 4'd1 == 4'(MATCH_CNT)) begin
              state_d   = ALIGNED;
              aligned_d = 1'b1;
              match_d   = 4'd0;
            end else begin
              match_d = match_q + 4'd1;
            end
          end else if (slip_q == 4'(MAX_SLIPS)) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else begin
            state_d = SLIP;
            align_d = 1'b1;
            slip_d  = slip_q + 4'd1;
            hi_d    = '0;
            match_d = 4'd0;
          end
        end
        SLIP: begin
          if (hi_q == HI_W'(ALIGN_HI - 1)) begin
            state_d  = SETTLE;
            align_d  = 1'b0;
            settle_d = 4'd0;
          end else begin
            hi_d = hi_q + {{(HI_W-1){1'b0}}, 1'b1};
          end
        end
        ALIGNED: state_d = ALIGNED;
        ERROR:   state_d = ERROR;
        default: begin
          state_d   = IDLE;
          align_d   = 1'b0;
          aligned_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      settle_q  <= 4'd0;
      match_q   <= 4'd0;
      hi_q      <= '0;
      align_q   <= 1'b0;
      aligned_q <= 1'b0;
      err_q     <= 1'b0;
      slip_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      match_q   <= match_d;
      hi_q      <= hi_d;
      align_q   <= align_d;
      aligned_q <= aligned_d;
      err_q     <= err_d;
      slip_q    <= slip_d;
    end
  end

  assign rx_data_align_o = align_q;
  assign aligned_o       = aligned_q;
  assign align_err_o     = err_q;
  assign slip_cnt_o      = slip_q;

`ifdef LVDS_ALIGN_STAT_EN
  logic [15:0] realign_q;

  // Counts only lock losses out of ALIGNED; start does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      realign_q <= 16'h0000;
    end else if (lock_lost_s && (state_q == ALIGNED) && (realign_q != 16'hFFFF)) begin
      realign_q <= realign_q + 16'h0001;
    end else begin
      realign_q <= realign_q;
    end
  end

  assign realign_cnt_o = realign_q;
`else
  assign realign_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_lvds_align_ctrl.sv
// Scoreboard bench for lvds_align_ctrl: expected link outcomes are queued at each start/relock.
`timescale 1ns/1ps
module tb_lvds_align_ctrl;

  localparam int         DW     = 8;
  localparam logic [7:0] PAT    = 8'hF1;
  localparam int         MATCH  = 4;
  localparam int         SETTLE = 6;
  localparam int         HI     = 2;
  localparam int         MAXS   = 8;
  localparam logic [7:0] USER   = 8'h22;
`ifdef LVDS_ALIGN_STAT_EN
  localparam logic [15:0] STAT_INC = 16'd1;
`else
  localparam logic [15:0] STAT_INC = 16'd0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          tx_locked;
  logic          rx_locked;
  logic [DW-1:0] rx_data;
  logic [DW-1:0] user_tx;
  logic [DW-1:0] tx_in;
  logic          rx_data_align;
  logic          aligned;
  logic          align_err;
  logic [3:0]    slip_cnt;
  logic [15:0]   realign_cnt;

  always #5 clk = ~clk;

  lvds_align_ctrl #(
    .DATA_W(DW), .TRAIN_PAT(PAT), .MATCH_CNT(MATCH),
    .SETTLE_CYC(SETTLE), .ALIGN_HI(HI), .MAX_SLIPS(MAXS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start),
    .tx_locked_i(tx_locked), .rx_locked_i(rx_locked),
    .rx_data_i(rx_data), .user_tx_i(user_tx),
    .tx_in_o(tx_in), .rx_data_align_o(rx_data_align),
    .aligned_o(aligned), .align_err_o(align_err),
    .slip_cnt_o(slip_cnt), .realign_cnt_o(realign_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bitslip pulse monitor: pulse count, widths, shortest low gap between pulses.
  int pulses = 0;
  int cur_w = 0;
  int widths[$];
  int cyc = 0;
  int last_fall = -1;
  int min_gap = 1000;

  always @(negedge clk) begin
    cyc++;
    if (rx_data_align) begin
      if (cur_w == 0) begin
        pulses++;
        if (last_fall >= 0 && (cyc - last_fall) < min_gap) min_gap = cyc - last_fall;
      end
      cur_w++;
    end else if (cur_w != 0) begin
      widths.push_back(cur_w);
      cur_w = 0;
      last_fall = cyc;
    end
  end

  // Receiver model: in rotate mode the word lines up after exactly 3 slips.
  logic       rx_rot;
  logic [7:0] rx_fixed;

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    int k;
    k = n % 8;
    return (k == 0) ? v : ((v << k) | (v >> (8 - k)));
  endfunction

  assign rx_data = rx_rot ? rotl(PAT, (pulses >= 3) ? 0 : 3 - pulses) : rx_fixed;

  typedef struct {
    logic        al;
    logic        err;
    logic [3:0]  sc;
    int          np;
    logic [7:0]  tx;
    logic [15:0] rc;
  } exp_t;
  exp_t sb[$];
  logic [15:0] rc_model = 16'd0;

  task automatic mon_clear();
    pulses = 0;
    cur_w = 0;
    widths.delete();
    last_fall = -1;
    min_gap = 1000;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 mon_clear();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = 0;
    while (!(aligned || align_err) && lat < budget) begin
      @(posedge clk);
      #1 lat++;
    end
    chk_eq("done_in_time", {31'd0, aligned | align_err}, 32'd1);
  endtask

  task automatic compare_done();
    exp_t e;
    chk_eq("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk_eq("aligned", {31'd0, aligned}, {31'd0, e.al});
      chk_eq("align_err", {31'd0, align_err}, {31'd0, e.err});
      chk_eq("slip_cnt", {28'd0, slip_cnt}, {28'd0, e.sc});
      chk_eq("pulses", pulses, e.np);
      chk_eq("tx_in_user", {24'd0, tx_in}, {24'd0, e.tx});
      chk_eq("realign_cnt", {16'd0, realign_cnt}, {16'd0, e.rc});
    end
  endtask

  task automatic wait_slip_high();
    int n;
    n = 0;
    while (!rx_data_align && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_eq("slip_seen", {31'd0, rx_data_align}, 32'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk_eq({tag, "_align"}, {31'd0, rx_data_align}, 32'd0);
    chk_eq({tag, "_aligned"}, {31'd0, aligned}, 32'd0);
    chk_eq({tag, "_err"}, {31'd0, align_err}, 32'd0);
    chk_eq({tag, "_slip"}, {28'd0, slip_cnt}, 32'd0);
    chk_eq({tag, "_rc"}, {16'd0, realign_cnt}, 32'd0);
    chk_eq({tag, "_tx"}, {24'd0, tx_in}, {24'd0, USER});
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; start = 1'b0; tx_locked = 1'b1; rx_locked = 1'b1;
    rx_rot = 1'b0; rx_fixed = PAT; user_tx = USER;
    #23 chk_reset_outs("rst");
    @(negedge clk) rst_n = 1'b1;

    // Already aligned: no slips, fixed latency from start.
    sb.push_back('{1'b1, 1'b0, 4'd0, 0, USER, rc_model});
    pulse_start();
    chk_eq("tx_train", {24'd0, tx_in}, {24'd0, PAT});
    wait_done(200, lat);
    chk_eq("latency", lat, 1 + SETTLE + MATCH);
    compare_done();

    // Three slips needed.
    rx_rot = 1'b1;
    sb.push_back('{1'b1, 1'b0, 4'd3, 3, USER, rc_model});
    pulse_start();
    wait_done(400, lat);
    compare_done();
    chk_eq("n_widths", widths.size(), 3);
    foreach (widths[i]) chk_eq("slip_width", widths[i], HI);
    chk_eq("slip_gap", {31'd0, min_gap >= SETTLE}, 32'd1);

    // Never matches: error after MAX_SLIPS.
    rx_rot = 1'b0; rx_fixed = 8'h00;
    sb.push_back('{1'b0, 1'b1, 4'(MAXS), MAXS, USER, rc_model});
    pulse_start();
    wait_done(1500, lat);
    compare_done();
    @(negedge clk) tx_locked = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("err_hold", {31'd0, align_err}, 32'd1);
    chk_eq("err_tx", {24'd0, tx_in}, {24'd0, USER});
    tx_locked = 1'b1;
    rx_fixed = PAT;
    sb.push_back('{1'b1, 1'b0, 4'd0, 0, USER, rc_model});
    pulse_start();
    chk_eq("err_clr", {31'd0, align_err}, 32'd0);
    wait_done(200, lat);
    compare_done();

    // Lock loss while aligned.
    @(negedge clk) rx_locked = 1'b0;
    @(posedge clk);
    #1 rc_model = rc_model + STAT_INC;
    chk_eq("ll_aligned", {31'd0, aligned}, 32'd0);
    chk_eq("ll_tx", {24'd0, tx_in}, {24'd0, PAT});
    chk_eq("ll_slip", {28'd0, slip_cnt}, 32'd0);
    chk_eq("ll_rc", {16'd0, realign_cnt}, {16'd0, rc_model});
    repeat (4) @(negedge clk);
    rx_locked = 1'b1;
    sb.push_back('{1'b1, 1'b0, 4'd0, 0, USER, rc_model});
    mon_clear();
    wait_done(200, lat);
    compare_done();

    // Lock drops during the first bitslip cycle.
    rx_fixed = 8'h00;
    pulse_start();
    wait_slip_high();
    tx_locked = 1'b0;
    @(posedge clk);
    #1 chk_eq("ms_align", {31'd0, rx_data_align}, 32'd0);
    chk_eq("ms_slip", {28'd0, slip_cnt}, 32'd0);
    repeat (5) @(posedge clk);
    #1 chk_eq("ms_wait_tx", {24'd0, tx_in}, {24'd0, PAT});
    chk_eq("ms_wait_align", {31'd0, rx_data_align | aligned}, 32'd0);
    chk_eq("ms_width_n", widths.size(), 1);
    if (widths.size() > 0) chk_eq("ms_width", widths[0], 1);
    chk_eq("ms_rc_kept", {16'd0, realign_cnt}, {16'd0, rc_model});
    tx_locked = 1'b1;

    // Async reset in CHECK after two matches.
    rx_fixed = PAT;
    pulse_start();
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk_eq("pre_rst_aligned", {31'd0, aligned}, 32'd0);
    chk_eq("pre_rst_tx", {24'd0, tx_in}, {24'd0, PAT});
    rst_n = 1'b0;
    #1 chk_reset_outs("arst");
    @(negedge clk) rst_n = 1'b1;
    rc_model = 16'd0;

    // Async reset while bitslip is high.
    rx_fixed = 8'h00;
    pulse_start();
    wait_slip_high();
    #2 rst_n = 1'b0;
    #1 chk_eq("arst_slip", {31'd0, rx_data_align}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
